rocc_cmd_arbiter: RTL and testbench

- Shares one RoCC neuro-accelerator command port among NUM_REQ requesters (cores or DMA engines).
- Round-robin arbitration; only one command in flight at a time.
- Legal funct7 opcodes (1..5) are forwarded using the accelerator's valid/ready protocol.
- Completion is inferred when the accelerator's ready re-rises, and is reported to the owning requester.
- Illegal opcodes and hung operations are reported as errors.

---
 rtl/rocc_sched_pkg.sv | 35 +++
 rtl/rr_pick.sv | 32 +++
 rtl/rocc_cmd_arbiter.sv | 178 +++++++++++++++++
 tb/tb_rocc_cmd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_sched_pkg.sv
// Shared definitions for RoCC command scheduling blocks: FSM encodings,
// legal neuro-accelerator opcodes, error codes and instruction field offsets.
package rocc_sched_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_CHECK     = 3'd1;
    localparam logic [STATE_W-1:0] ST_ISSUE     = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_LOW  = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd4;

    localparam logic [6:0] FN_OP1 = 7'd1;
    localparam logic [6:0] FN_OP2 = 7'd2;
    localparam logic [6:0] FN_OP3 = 7'd3;
    localparam logic [6:0] FN_OP4 = 7'd4;
    localparam logic [6:0] FN_OP5 = 7'd5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // The low five opcode bits are dropped on the request bus.
    localparam int unsigned INST_LSB   = 5;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_MSB = 31;
    localparam int unsigned FUNCT7_W   = FUNCT7_MSB - FUNCT7_LSB + 1;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_MSB     = 11;

    function automatic logic funct7_legal(input logic [6:0] f7);
        return (f7 >= FN_OP1) && (f7 <= FN_OP5);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N, returned as a one-hot grant plus its index.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IW'((32'(ptr) + k) % N);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/rocc_cmd_arbiter.sv
// Shares one RoCC accelerator command port among NUM_REQ requesters with
// round-robin arbitration and a single command in flight.
module rocc_cmd_arbiter
    import rocc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*(INST_WIDTH-5)-1:0]    req_inst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_rs1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_rs2,
    output logic [NUM_REQ-1:0]                   rsp_done,
    output logic [NUM_REQ-1:0]                   rsp_err,
    output logic [1:0]                           rsp_err_code,
    output logic                                 acc_valid,
    input  logic                                 acc_ready,
    output logic [INST_WIDTH-6:0]                acc_inst,
    output logic [DATA_WIDTH-1:0]                acc_rs1,
    output logic [DATA_WIDTH-1:0]                acc_rs2,
    output logic                                 busy,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id
);

    localparam int unsigned IW     = $clog2(NUM_REQ);
    localparam int unsigned CW     = INST_WIDTH - INST_LSB;
    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned TW     = $clog2(TIMEOUT + 1);
    localparam int unsigned F7_POS = FUNCT7_LSB - INST_LSB;

    logic [STATE_W-1:0] state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [IW-1:0]      grant_d, nxt_ptr;
    logic               valid_d;
    logic [CW-1:0]      inst_d, inst_sel;
    logic [DW-1:0]      rs1_d, rs2_d, rs1_sel, rs2_sel;
    logic [NUM_REQ-1:0] done_d, err_d;
    logic [1:0]         code_d;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic               in_flight, completed, timeout_hit;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Payload of the current round-robin winner.
    always_comb begin
        inst_sel = '0;
        rs1_sel  = '0;
        rs2_sel  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                inst_sel = req_inst[i*CW +: CW];
                rs1_sel  = req_rs1[i*DW +: DW];
                rs2_sel  = req_rs2[i*DW +: DW];
            end
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign nxt_ptr     = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
    assign in_flight   = (state_q == ST_ISSUE) || (state_q == ST_WAIT_LOW) ||
                         (state_q == ST_WAIT_DONE);
    assign completed   = (state_q == ST_WAIT_DONE) && acc_ready;
    assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        timer_d   = timer_q;
        grant_d   = grant_id;
        valid_d   = acc_valid;
        inst_d    = acc_inst;
        rs1_d     = acc_rs1;
        rs2_d     = acc_rs2;
        done_d    = '0;
        err_d     = '0;
        code_d    = ERR_NONE;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = pick_grant;
                if (pick_found) begin
                    inst_d  = inst_sel;
                    rs1_d   = rs1_sel;
                    rs2_d   = rs2_sel;
                    grant_d = pick_idx;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (funct7_legal(acc_inst[F7_POS +: FUNCT7_W])) begin
                    valid_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_ISSUE;
                end else begin
                    err_d[grant_id] = 1'b1;
                    code_d          = ERR_ILLEGAL;
                    rr_ptr_d        = nxt_ptr;
                    state_d         = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (acc_valid && acc_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!acc_ready) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (acc_ready) begin
                    done_d[grant_id] = 1'b1;
                    rr_ptr_d         = nxt_ptr;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion on the last allowed cycle beats the timeout.
        if (in_flight) begin
            timer_d = timer_q + TW'(1);
            if (timeout_hit && !completed) begin
                err_d           = '0;
                err_d[grant_id] = 1'b1;
                code_d          = ERR_TIMEOUT;
                valid_d         = 1'b0;
                rr_ptr_d        = nxt_ptr;
                state_d         = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            timer_q      <= '0;
            grant_id     <= '0;
            acc_valid    <= 1'b0;
            acc_inst     <= '0;
            acc_rs1      <= '0;
            acc_rs2      <= '0;
            rsp_done     <= '0;
            rsp_err      <= '0;
            rsp_err_code <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            timer_q      <= timer_d;
            grant_id     <= grant_d;
            acc_valid    <= valid_d;
            acc_inst     <= inst_d;
            acc_rs1      <= rs1_d;
            acc_rs2      <= rs2_d;
            rsp_done     <= done_d;
            rsp_err      <= err_d;
            rsp_err_code <= code_d;
        end
    end

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Directed bench for rocc_cmd_arbiter: a long-timeout instance (a) and a
// TIMEOUT=16 instance (b); responses are checked against a scoreboard queue.
module tb_rocc_cmd_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned CW   = 27;
    localparam int unsigned DW   = 64;
    localparam int unsigned TO_B = 16;

    typedef struct packed {
        logic [NR-1:0] done;
        logic [NR-1:0] err;
        logic [1:0]    code;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic acc_rdy;
    logic [NR-1:0]    req_valid;
    logic [NR*CW-1:0] req_inst;
    logic [NR*DW-1:0] req_rs1, req_rs2;

    logic [NR-1:0] valid_a, valid_b, ready_a, ready_b, done_a, done_b, err_a, err_b;
    logic [1:0]    code_a, code_b, gid_a, gid_b;
    logic          accv_a, accv_b, accr_a, accr_b, busy_a, busy_b;
    logic [CW-1:0] inst_a, inst_b;
    logic [DW-1:0] rs1_a, rs1_b, rs2_a, rs2_b;

    logic [NR-1:0] cur_ready, cur_done, cur_err;
    logic [1:0]    cur_code, cur_gid;
    logic          cur_accv, cur_busy;
    logic [CW-1:0] cur_inst;
    logic [DW-1:0] cur_rs1, cur_rs2;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_rsp_cyc = 0;
    int   accept_cyc = 0;
    int   acc_seen = 0;
    exp_t exp_q[$];

    assign valid_a = sel ? '0 : req_valid;
    assign valid_b = sel ? req_valid : '0;
    assign accr_a  = sel ? 1'b1 : acc_rdy;
    assign accr_b  = sel ? acc_rdy : 1'b1;

    assign cur_ready = sel ? ready_b : ready_a;
    assign cur_done  = sel ? done_b  : done_a;
    assign cur_err   = sel ? err_b   : err_a;
    assign cur_code  = sel ? code_b  : code_a;
    assign cur_gid   = sel ? gid_b   : gid_a;
    assign cur_accv  = sel ? accv_b  : accv_a;
    assign cur_busy  = sel ? busy_b  : busy_a;
    assign cur_inst  = sel ? inst_b  : inst_a;
    assign cur_rs1   = sel ? rs1_b   : rs1_a;
    assign cur_rs2   = sel ? rs2_b   : rs2_a;

    rocc_cmd_arbiter #(.NUM_REQ(NR), .INST_WIDTH(32), .DATA_WIDTH(DW), .TIMEOUT(1024)) dut_a (
        .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a),
        .req_inst(req_inst), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_done(done_a), .rsp_err(err_a), .rsp_err_code(code_a),
        .acc_valid(accv_a), .acc_ready(accr_a), .acc_inst(inst_a),
        .acc_rs1(rs1_a), .acc_rs2(rs2_a), .busy(busy_a), .grant_id(gid_a)
    );

    rocc_cmd_arbiter #(.NUM_REQ(NR), .INST_WIDTH(32), .DATA_WIDTH(DW), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b),
        .req_inst(req_inst), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_done(done_b), .rsp_err(err_b), .rsp_err_code(code_b),
        .acc_valid(accv_b), .acc_ready(accr_b), .acc_inst(inst_b),
        .acc_rs1(rs1_b), .acc_rs2(rs2_b), .busy(busy_b), .grant_id(gid_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [NR-1:0] d, input logic [NR-1:0] e, input logic [1:0] c);
        exp_t r;
        r.done = d;
        r.err  = e;
        r.code = c;
        return r;
    endfunction

    function automatic logic [CW-1:0] inst_of(input int i, input logic [6:0] f7);
        return {f7, 20'h0A500 + 20'(i)};
    endfunction

    // One clock; any response pulse is matched against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (cur_accv) acc_seen = 1;
        if ((cur_done | cur_err) != '0) begin
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'({cur_done, cur_err}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_done", 64'(cur_done), 64'(e.done));
                chk("rsp_err", 64'(cur_err), 64'(e.err));
                chk("rsp_code", 64'(cur_code), 64'(e.code));
            end
        end
    endtask

    task automatic drive(input int i, input logic [6:0] f7, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_inst[i*CW +: CW] = inst_of(i, f7);
        req_rs1[i*DW +: DW]  = a;
        req_rs2[i*DW +: DW]  = b;
        req_valid[i]         = 1'b1;
    endtask

    // Waits for an offer, checks it, and steps past the handshake edge.
    task automatic wait_grant(input int exp_id, input string tag);
        int n = 0;
        #1;
        while (cur_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_onehot"}, 64'($countones(cur_ready)), 64'd1);
        chk({tag, "_id"}, 64'(cur_ready), 64'd1 << exp_id);
        accept_cyc = cyc;
        tick();
        chk({tag, "_gid"}, 64'(cur_gid), 64'(exp_id));
    endtask

    task automatic wait_sb(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; acc_rdy = 1'b1;
        req_valid = '0; req_inst = '0; req_rs1 = '0; req_rs2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        chk("reset_busy", 64'(cur_busy), 64'd0);
        chk("reset_accv", 64'(cur_accv), 64'd0);
        chk("reset_ready", 64'(cur_ready), 64'd0);
        chk("reset_gid", 64'(cur_gid), 64'd0);
        chk("reset_inst", 64'(cur_inst), 64'd0);
        chk("reset_rsp", 64'({cur_done, cur_err, cur_code}), 64'd0);

        // Single legal command from requester 0.
        drive(0, 7'd1, 64'h3F800000_40000000, 64'h00000001_00000002);
        exp_q.push_back(mk(4'b0001, 4'b0000, 2'b00));
        wait_grant(0, "t1_grant");
        req_valid = '0;
        chk("t1_accv_n1", 64'(cur_accv), 64'd0);
        chk("t1_busy", 64'(cur_busy), 64'd1);
        tick();
        chk("t1_accv_n2", 64'(cur_accv), 64'd1);
        chk("t1_inst", 64'(cur_inst), 64'(inst_of(0, 7'd1)));
        chk("t1_rs1", cur_rs1, 64'h3F800000_40000000);
        chk("t1_rs2", cur_rs2, 64'h00000001_00000002);
        tick();
        chk("t1_accv_drop", 64'(cur_accv), 64'd0);
        acc_rdy = 1'b0;
        repeat (20) tick();
        acc_rdy = 1'b1;
        wait_sb(5, "t1");
        chk("t1_busy_after", 64'(cur_busy), 64'd0);
        tick();

        // Illegal funct7 from requester 2.
        acc_seen = 0;
        drive(2, 7'h09, 64'hDEAD, 64'hBEEF);
        exp_q.push_back(mk(4'b0000, 4'b0100, 2'b01));
        wait_grant(2, "ill_grant");
        req_valid = '0;
        wait_sb(10, "ill");
        chk("ill_latency", 64'(last_rsp_cyc - accept_cyc), 64'd2);
        chk("ill_no_accv", 64'(acc_seen), 64'd0);

        // Pointer is now 3; reset in the middle of WAIT_DONE.
        drive(1, 7'd5, 64'h11, 64'h22);
        drive(3, 7'd5, 64'h33, 64'h44);
        wait_grant(3, "rrptr3");
        req_valid = '0;
        tick();
        tick();
        acc_rdy = 1'b0;
        tick();
        tick();
        chk("rst_pre_busy", 64'(cur_busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_busy", 64'(cur_busy), 64'd0);
        chk("rst_async_accv", 64'(cur_accv), 64'd0);
        chk("rst_async_gid", 64'(cur_gid), 64'd0);
        chk("rst_async_inst", 64'(cur_inst), 64'd0);
        chk("rst_async_rs1", cur_rs1, 64'd0);
        chk("rst_async_rsp", 64'({cur_done, cur_err, cur_code}), 64'd0);
        acc_rdy = 1'b1;
        #3 rst = 1'b1;

        // All four contend continuously: grants rotate 0,1,2,3,0.
        for (int k = 0; k < 4; k++) drive(k, 7'd2, 64'(k) * 64'h1111, ~64'(k));
        for (int n = 0; n < 5; n++) begin
            int id;
            id = n % 4;
            exp_q.push_back(mk(4'b0001 << id, 4'b0000, 2'b00));
            wait_grant(id, "rr_grant");
            tick();
            chk("rr_inst", 64'(cur_inst), 64'(inst_of(id, 7'd2)));
            chk("rr_rs1", cur_rs1, 64'(id) * 64'h1111);
            tick();
            acc_rdy = 1'b0;
            repeat (3) tick();
            acc_rdy = 1'b1;
            wait_sb(5, "rr");
        end
        req_valid = '0;

        // Short-timeout instance with the accelerator stuck busy.
        @(posedge clk);
        #1 sel = 1'b1; acc_rdy = 1'b0; rst = 1'b0;
        #3 rst = 1'b1;
        drive(1, 7'd3, 64'h55, 64'h66);
        exp_q.push_back(mk(4'b0000, 4'b0010, 2'b10));
        wait_grant(1, "to_grant");
        req_valid = '0;
        wait_sb(30, "to");
        chk("to_latency", 64'(last_rsp_cyc - accept_cyc), 64'(2 + TO_B));
        chk("to_accv", 64'(cur_accv), 64'd0);
        chk("to_busy", 64'(cur_busy), 64'd0);

        // Next command waits in ISSUE until ready is released.
        drive(3, 7'd4, 64'h77, 64'h88);
        exp_q.push_back(mk(4'b1000, 4'b0000, 2'b00));
        wait_grant(3, "to_next_grant");
        req_valid = '0;
        tick();
        repeat (5) tick();
        chk("to_next_hold_accv", 64'(cur_accv), 64'd1);
        chk("to_next_hold_inst", 64'(cur_inst), 64'(inst_of(3, 7'd4)));
        acc_rdy = 1'b1;
        tick();
        chk("to_next_accv_drop", 64'(cur_accv), 64'd0);
        acc_rdy = 1'b0;
        repeat (4) tick();
        acc_rdy = 1'b1;
        wait_sb(5, "to_next");

        // Completion lands on the timeout cycle: done only.
        drive(0, 7'd5, 64'h99, 64'hAA);
        exp_q.push_back(mk(4'b0001, 4'b0000, 2'b00));
        wait_grant(0, "tie_grant");
        req_valid = '0;
        tick();
        tick();
        acc_rdy = 1'b0;
        repeat (TO_B - 2) tick();
        acc_rdy = 1'b1;
        wait_sb(3, "tie");
        chk("tie_latency", 64'(last_rsp_cyc - accept_cyc), 64'(2 + TO_B));
        tick();
        chk("tie_busy", 64'(cur_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
